// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: byte-wide instruction memory port,
// redirect request, and the instruction valid/ready handshake toward the datapath.
interface instr_fetch_unit_if;
    logic [4:0]  imem_addr;
    logic [7:0]  imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] fetch_pc;

    modport master (
        output imem_addr, inst_valid, inst, inst_pc, fetch_pc,
        input  imem_data, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst, inst_pc, fetch_pc,
        output imem_data, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: assembles big-endian 32-bit words from a 32-byte memory
// into a small queue. Define IFU_PREFETCH_QUEUE_EN for a 2-entry queue (default: 1 entry).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);

`ifdef IFU_PREFETCH_QUEUE_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    // With a single entry both pointers stay at slot 0.
    localparam logic       PTR_STEP  = (DEPTH > 1);
    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [1:0]  k_reg, k_next;
    logic [31:8] asm_reg, asm_next;
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic        wr_ptr_reg, wr_ptr_next;

    logic [31:0] slot_data [2];
    logic [31:0] slot_pc   [2];
    logic        full;
    logic        pop;
    logic        push;
    logic [31:0] word;

    assign full = (count_reg == DEPTH_CNT);
    assign pop  = (count_reg != 2'd0) && bus.inst_ready;
    // A full queue still accepts the word when the head leaves in the same cycle.
    assign push = (k_reg == 2'd3) && (!full || pop);
    assign word = {asm_reg, bus.imem_data};

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        k_next        = k_reg;
        asm_next      = asm_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        if (bus.redirect) begin
            fetch_pc_next = bus.redirect_pc & ~32'h0000_0003;
            k_next        = 2'd0;
            asm_next      = '0;
            count_next    = 2'd0;
            rd_ptr_next   = 1'b0;
            wr_ptr_next   = 1'b0;
        end else begin
            if (push) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
                k_next        = 2'd0;
                wr_ptr_next   = wr_ptr_reg ^ PTR_STEP;
            end else if (k_reg != 2'd3) begin
                k_next = k_reg + 2'd1;
                case (k_reg)
                    2'd0:    asm_next[31:24] = bus.imem_data;
                    2'd1:    asm_next[23:16] = bus.imem_data;
                    default: asm_next[15:8]  = bus.imem_data;
                endcase
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg ^ PTR_STEP;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            k_reg        <= 2'd0;
            asm_reg      <= '0;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            k_reg        <= k_next;
            asm_reg      <= asm_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // Queue slots; stale contents are masked off by the count, so no reset is needed.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [31:0] data_reg;
        logic [31:0] pc_reg;
        logic        wr_en;

        assign wr_en = !reset && !bus.redirect && push && (wr_ptr_reg == 1'(gi));

        always_ff @(posedge clk) begin
            if (wr_en) begin
                data_reg <= word;
                pc_reg   <= fetch_pc_reg;
            end
        end

        assign slot_data[gi] = data_reg;
        assign slot_pc[gi]   = pc_reg;
    end

    assign bus.imem_addr  = fetch_pc_reg[4:0] + {3'b000, k_reg};
    assign bus.inst_valid = (count_reg != 2'd0);
    assign bus.inst       = bus.inst_valid ? slot_data[rd_ptr_reg] : 32'h0;
    assign bus.inst_pc    = bus.inst_valid ? slot_pc[rd_ptr_reg]   : 32'h0;
    assign bus.fetch_pc   = fetch_pc_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// compared against a word-level model of the fetch stream and instruction queue.
module tb_instr_fetch_unit;

`ifdef IFU_PREFETCH_QUEUE_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mem [32];

    always #5 clk = ~clk;

    instr_fetch_unit_if ifc0 ();
    instr_fetch_unit_if ifc1 ();

    assign ifc0.imem_data = mem[ifc0.imem_addr];
    assign ifc1.imem_data = mem[ifc1.imem_addr];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .reset(reset), .bus(ifc0));
    instr_fetch_unit #(.RESET_PC(32'd30))        dut1 (.clk(clk), .reset(reset), .bus(ifc1));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: next fetch address, bytes already fetched for it, and queued (pc, word) pairs.
    logic [31:0] m_pc;
    int          m_prog;
    logic [31:0] m_qpc[$];
    logic [31:0] m_qword[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        logic [4:0]  ad;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            ad = a[4:0] + 5'(i);
            w  = {w[23:0], mem[ad]};
        end
        return w;
    endfunction

    task automatic model_step(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        if (r) begin
            m_pc = 32'h0; m_prog = 0; m_qpc.delete(); m_qword.delete();
        end else if (rd) begin
            m_pc = {rpc[31:2], 2'b00}; m_prog = 0; m_qpc.delete(); m_qword.delete();
        end else begin
            if (m_qpc.size() > 0 && rdy) begin
                void'(m_qpc.pop_front());
                void'(m_qword.pop_front());
            end
            if (m_prog == 3 && m_qpc.size() < DEPTH) begin
                m_qpc.push_back(m_pc);
                m_qword.push_back(mem_word(m_pc));
                m_pc   = m_pc + 32'd4;
                m_prog = 0;
            end else if (m_prog < 3) begin
                m_prog++;
            end
        end
    endtask

    task automatic tick(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        reset            = r;
        ifc0.inst_ready  = rdy;
        ifc0.redirect    = rd;
        ifc0.redirect_pc = rpc;
        model_step(r, rdy, rd, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        n_tests++; if (ifc0.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", ifc0.inst_valid); end
        n_tests++; if (ifc0.inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h exp 0", ifc0.inst); end
        n_tests++; if (ifc0.inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h exp 0", ifc0.inst_pc); end
        n_tests++; if (ifc0.imem_addr !== 5'd0) begin n_fail++; $display("FAIL reset_imem_addr: got %h exp 0", ifc0.imem_addr); end
        n_tests++; if (ifc0.fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_pc: got %h exp 0", ifc0.fetch_pc); end
        n_tests++; if (ifc1.imem_addr !== 5'd30) begin n_fail++; $display("FAIL reset_imem_addr_rpc30: got %h exp 1e", ifc1.imem_addr); end
        n_tests++; if (ifc1.fetch_pc !== 32'd30) begin n_fail++; $display("FAIL reset_fetch_pc_rpc30: got %h exp 1e", ifc1.fetch_pc); end
        n_tests++; if (ifc1.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_rpc30: got %b exp 0", ifc1.inst_valid); end
    endtask

    task automatic test_first_word();
        logic [4:0]  a1 [4];
        logic [31:0] w30;
        a1  = '{5'd30, 5'd31, 5'd0, 5'd1};
        w30 = {mem[30], mem[31], 8'h8C, 8'h01};
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (ifc0.inst_valid !== 1'b0) begin n_fail++; $display("FAIL first_latency_valid[%0d]: got %b exp 0", i, ifc0.inst_valid); end
            n_tests++; if (ifc0.imem_addr !== 5'(i)) begin n_fail++; $display("FAIL first_addr[%0d]: got %h exp %h", i, ifc0.imem_addr, i); end
            n_tests++; if (ifc1.imem_addr !== a1[i]) begin n_fail++; $display("FAIL wrap30_addr[%0d]: got %h exp %h", i, ifc1.imem_addr, a1[i]); end
            tick(0, 1, 0, 0);
        end
        n_tests++; if (ifc0.inst_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b exp 1", ifc0.inst_valid); end
        n_tests++; if (ifc0.inst !== 32'h8C01_0004) begin n_fail++; $display("FAIL first_inst: got %h exp 8c010004", ifc0.inst); end
        n_tests++; if (ifc0.inst_pc !== 32'h0) begin n_fail++; $display("FAIL first_inst_pc: got %h exp 0", ifc0.inst_pc); end
        n_tests++; if (ifc0.fetch_pc !== 32'h4) begin n_fail++; $display("FAIL first_fetch_pc: got %h exp 4", ifc0.fetch_pc); end
        n_tests++; if (ifc1.inst_valid !== 1'b1 || ifc1.inst_pc !== 32'd30) begin n_fail++; $display("FAIL wrap30_pc: got v=%b pc=%h exp v=1 pc=1e", ifc1.inst_valid, ifc1.inst_pc); end
        n_tests++; if (ifc1.inst !== w30) begin n_fail++; $display("FAIL wrap30_inst: got %h exp %h", ifc1.inst, w30); end
        n_tests++; if (ifc1.fetch_pc !== 32'd34) begin n_fail++; $display("FAIL wrap30_fetch_pc: got %h exp 22", ifc1.fetch_pc); end
        tick(0, 1, 0, 0);
        n_tests++; if (ifc0.inst_valid !== 1'b0) begin n_fail++; $display("FAIL first_pop_empty: got %b exp 0", ifc0.inst_valid); end
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        n_tests++; if (ifc0.inst_valid !== 1'b1 || ifc0.inst_pc !== 32'h4) begin n_fail++; $display("FAIL second_word: got v=%b pc=%h exp v=1 pc=4", ifc0.inst_valid, ifc0.inst_pc); end
        n_tests++; if (ifc0.inst !== mem_word(32'h4)) begin n_fail++; $display("FAIL second_inst: got %h exp %h", ifc0.inst, mem_word(32'h4)); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_fpc;
        logic [31:0] nxt;
        logic        rdy;
        exp_fpc = (DEPTH == 2) ? 32'h8 : 32'h4;
        nxt     = 32'h0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);
        n_tests++; if (ifc0.inst_valid !== 1'b1 || ifc0.inst_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head: got v=%b pc=%h exp v=1 pc=0", ifc0.inst_valid, ifc0.inst_pc); end
        n_tests++; if (ifc0.fetch_pc !== exp_fpc) begin n_fail++; $display("FAIL stall_fetch_pc: got %h exp %h", ifc0.fetch_pc, exp_fpc); end
        n_tests++; if (ifc0.imem_addr !== exp_fpc[4:0] + 5'd3) begin n_fail++; $display("FAIL stall_addr: got %h exp %h", ifc0.imem_addr, exp_fpc[4:0] + 5'd3); end
        tick(0, 0, 0, 0);
        n_tests++; if (ifc0.imem_addr !== exp_fpc[4:0] + 5'd3) begin n_fail++; $display("FAIL stall_addr_frozen: got %h exp %h", ifc0.imem_addr, exp_fpc[4:0] + 5'd3); end
        for (int c = 0; c < 40; c++) begin
            rdy = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (ifc0.inst_valid && rdy) begin
                n_tests++; if (ifc0.inst_pc !== nxt || ifc0.inst !== mem_word(nxt)) begin n_fail++; $display("FAIL stall_order: got pc=%h inst=%h exp pc=%h inst=%h", ifc0.inst_pc, ifc0.inst, nxt, mem_word(nxt)); end
                nxt = nxt + 32'd4;
            end
            tick(0, rdy, 0, 0);
            if (c == 0) begin
                n_tests++; if (ifc0.inst_valid !== 1'b1 || ifc0.inst_pc !== 32'h4) begin n_fail++; $display("FAIL stall_release: got v=%b pc=%h exp v=1 pc=4", ifc0.inst_valid, ifc0.inst_pc); end
            end
        end
        n_tests++; if (nxt < 32'd12) begin n_fail++; $display("FAIL stall_progress: got %0d words exp >= 3", nxt / 4); end
    endtask

    task automatic test_redirect();
        tick(1, 1, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        n_tests++; if (ifc0.imem_addr !== 5'd2) begin n_fail++; $display("FAIL redir_k2_addr: got %h exp 2", ifc0.imem_addr); end
        tick(0, 1, 1, 32'h0000_0013);
        n_tests++; if (ifc0.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b exp 0", ifc0.inst_valid); end
        n_tests++; if (ifc0.fetch_pc !== 32'h10) begin n_fail++; $display("FAIL redir_fetch_pc: got %h exp 10", ifc0.fetch_pc); end
        n_tests++; if (ifc0.imem_addr !== 5'h10) begin n_fail++; $display("FAIL redir_addr: got %h exp 10", ifc0.imem_addr); end
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        n_tests++; if (ifc0.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_latency: got %b exp 0", ifc0.inst_valid); end
        tick(0, 1, 0, 0);
        n_tests++; if (ifc0.inst_valid !== 1'b1 || ifc0.inst_pc !== 32'h10) begin n_fail++; $display("FAIL redir_first: got v=%b pc=%h exp v=1 pc=10", ifc0.inst_valid, ifc0.inst_pc); end
        n_tests++; if (ifc0.inst !== mem_word(32'h10)) begin n_fail++; $display("FAIL redir_inst: got %h exp %h", ifc0.inst, mem_word(32'h10)); end
    endtask

    task automatic test_wrap();
        tick(0, 1, 1, 32'd28);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
        n_tests++; if (ifc0.inst_valid !== 1'b1 || ifc0.inst_pc !== 32'd28) begin n_fail++; $display("FAIL wrap28_pc: got v=%b pc=%h exp v=1 pc=1c", ifc0.inst_valid, ifc0.inst_pc); end
        n_tests++; if (ifc0.inst !== mem_word(32'd28)) begin n_fail++; $display("FAIL wrap28_inst: got %h exp %h", ifc0.inst, mem_word(32'd28)); end
        n_tests++; if (ifc0.fetch_pc !== 32'd32) begin n_fail++; $display("FAIL wrap28_fetch_pc: got %h exp 20", ifc0.fetch_pc); end
        n_tests++; if (ifc0.imem_addr !== 5'd0) begin n_fail++; $display("FAIL wrap28_addr: got %h exp 0", ifc0.imem_addr); end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
        n_tests++; if (ifc0.inst_valid !== 1'b1 || ifc0.imem_addr !== 5'd6) begin n_fail++; $display("FAIL rstmid_setup: got v=%b addr=%h exp v=1 addr=6", ifc0.inst_valid, ifc0.imem_addr); end
        tick(1, 0, 0, 0);
        n_tests++; if (ifc0.inst_valid !== 1'b0 || ifc0.inst !== 32'h0) begin n_fail++; $display("FAIL rstmid_flush: got v=%b inst=%h exp v=0 inst=0", ifc0.inst_valid, ifc0.inst); end
        n_tests++; if (ifc0.fetch_pc !== 32'h0 || ifc0.imem_addr !== 5'd0) begin n_fail++; $display("FAIL rstmid_pc: got pc=%h addr=%h exp 0 0", ifc0.fetch_pc, ifc0.imem_addr); end
        tick(0, 0, 0, 0);
        n_tests++; if (ifc0.imem_addr !== 5'd1 || ifc0.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_restart: got addr=%h v=%b exp addr=1 v=0", ifc0.imem_addr, ifc0.inst_valid); end
    endtask

    task automatic test_random();
        logic        r, rd, rdy;
        logic [31:0] rpc, e_inst, e_pc;
        logic [4:0]  e_addr;
        tick(1, 0, 0, 0);
        for (int c = 0; c < 800; c++) begin
            r   = ($urandom_range(0, 99) == 0);
            rd  = ($urandom_range(0, 99) < 4);
            rdy = ($urandom_range(0, 99) < 65);
            rpc = $urandom;
            tick(r, rdy, rd, rpc);
            e_inst = (m_qword.size() > 0) ? m_qword[0] : 32'h0;
            e_pc   = (m_qpc.size() > 0) ? m_qpc[0] : 32'h0;
            e_addr = m_pc[4:0] + 5'(m_prog);
            n_tests++; if (ifc0.inst_valid !== (m_qpc.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b exp %b", c, ifc0.inst_valid, m_qpc.size() != 0); end
            n_tests++; if (ifc0.inst !== e_inst) begin n_fail++; $display("FAIL rnd_inst[%0d]: got %h exp %h", c, ifc0.inst, e_inst); end
            n_tests++; if (ifc0.inst_pc !== e_pc) begin n_fail++; $display("FAIL rnd_inst_pc[%0d]: got %h exp %h", c, ifc0.inst_pc, e_pc); end
            n_tests++; if (ifc0.fetch_pc !== m_pc) begin n_fail++; $display("FAIL rnd_fetch_pc[%0d]: got %h exp %h", c, ifc0.fetch_pc, m_pc); end
            n_tests++; if (ifc0.imem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h exp %h", c, ifc0.imem_addr, e_addr); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
        ifc0.inst_ready  = 1'b1;
        ifc0.redirect    = 1'b0;
        ifc0.redirect_pc = 32'h0;
        ifc1.inst_ready  = 1'b1;
        ifc1.redirect    = 1'b0;
        ifc1.redirect_pc = 32'h0;
        m_pc   = 32'h0;
        m_prog = 0;

        test_reset();
        test_first_word();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
